pe_feed_ctrl: RTL and testbench

PE_FEED_CTRL -- requirements
Module: pe_feed_ctrl

---
 rtl/pe_feed_ctrl.sv | 133 +++++++++++++
 tb/tb_pe_feed_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feed_ctrl.sv
// PE chain feed controller: activation FIFO, IDLE/FEED/DRAIN sequencing.
// Optional 16-bit fire counter enabled by macro PE_FEED_CNT_EN.
module pe_feed_ctrl #(
    parameter int DEPTH = 8,
    parameter int N_PE  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    input  logic        hold,
    output logic        fire,
    output logic [7:0]  out_a,
    output logic        done,
    output logic        busy
`ifdef PE_FEED_CNT_EN
    ,
    output logic [15:0] fire_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(N_PE + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FEED  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] drain_cnt;
    logic [8:0]    mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [8:0]    rd_word;

    // Extra pointer bit tells full from empty when the indices match
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign s_ready = ~full;
    assign push    = s_valid & ~full;
    assign pop     = (state != DRAIN) & ~empty & ~hold;
    assign rd_word = mem[rptr[AW-1:0]];
    assign busy    = (state != IDLE);

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= {s_last, s_data};
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Issue register towards the first PE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fire  <= 1'b0;
            out_a <= '0;
        end else begin
            fire <= pop;
            if (pop) out_a <= rd_word[7:0];
        end
    end

    // Sequencer: feed words, then drain the chain for N_PE cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FEED: begin
                    if (pop) begin
                        if (rd_word[8]) begin
                            state     <= DRAIN;
                            drain_cnt <= CW'(N_PE);
                        end else begin
                            state <= FEED;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt <= CW'(1)) begin
                        state     <= IDLE;
                        drain_cnt <= '0;
                        done      <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PE_FEED_CNT_EN
    logic start_vec;

    assign start_vec = (state == IDLE) & pop;

    // Fires per vector, restarted when a new vector begins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fire_cnt <= '0;
        end else if (start_vec) begin
            fire_cnt <= '0;
        end else if (fire && (fire_cnt != 16'hFFFF)) begin
            fire_cnt <= fire_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Directed testbench for pe_feed_ctrl (DEPTH=8, N_PE=4).
// Fire counter checks compile in when PE_FEED_CNT_EN is defined.
module tb_pe_feed_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        hold;
    logic        fire;
    logic [7:0]  out_a;
    logic        done;
    logic        busy;
`ifdef PE_FEED_CNT_EN
    logic [15:0] fire_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pe_feed_ctrl #(
        .DEPTH(8),
        .N_PE (4)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .hold   (hold),
        .fire   (fire),
        .out_a  (out_a),
        .done   (done),
        .busy   (busy)
`ifdef PE_FEED_CNT_EN
        ,
        .fire_cnt(fire_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        s_last = 1'b0;
        hold = 1'b0;
        #1 rstn = 1'b0;
        #2;
        total++;
        if (fire !== 1'b0 || out_a !== 8'h00 || done !== 1'b0 ||
            busy !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset fire=%b out_a=%h done=%b busy=%b rdy=%b want 0/00/0/0/1",
                     fire, out_a, done, busy, s_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11;
        exp_d[1] = 8'h22;
        exp_d[2] = 8'h33;
        s_valid = 1'b1;
        s_data = 8'h11;
        s_last = 1'b0;
        step();
        total++;
        if (fire !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency fire=%b want 0", fire);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                s_data = 8'h22;
            end else if (i == 1) begin
                s_data = 8'h33;
                s_last = 1'b1;
            end else begin
                s_valid = 1'b0;
                s_last = 1'b0;
            end
            step();
            total++;
            if (fire !== 1'b1 || out_a !== exp_d[i] || busy !== 1'b1) begin
                bad++;
                $display("FAIL basic_fire%0d fire=%b out_a=%h busy=%b want 1/%h/1",
                         i, fire, out_a, busy, exp_d[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (fire !== 1'b0 || done !== (i == 3) || busy !== (i != 3)) begin
                bad++;
                $display("FAIL basic_drain%0d fire=%b done=%b busy=%b want 0/%b/%b",
                         i, fire, done, busy, (i == 3), (i != 3));
            end
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || out_a !== 8'h33) begin
            bad++;
            $display("FAIL basic_idle done=%b busy=%b out_a=%h want 0/0/33",
                     done, busy, out_a);
        end
    endtask

    task automatic test_full_hold();
        hold = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_data = 8'h40 + 8'(k);
            s_last = (k == 7);
            step();
            total++;
            if (s_ready !== (k < 7) || fire !== 1'b0) begin
                bad++;
                $display("FAIL full_push%0d rdy=%b fire=%b want %b/0",
                         k, s_ready, fire, (k < 7));
            end
        end
        s_data = 8'h48;
        s_last = 1'b0;
        step();
        total++;
        if (s_ready !== 1'b0 || fire !== 1'b0) begin
            bad++;
            $display("FAIL full_ninth rdy=%b fire=%b want 0/0", s_ready, fire);
        end
        s_valid = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (fire !== 1'b1 || out_a !== (8'h40 + 8'(i)) || s_ready !== 1'b1) begin
                bad++;
                $display("FAIL full_fire%0d fire=%b out_a=%h rdy=%b want 1/%h/1",
                         i, fire, out_a, s_ready, 8'h40 + 8'(i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (fire !== 1'b0 || done !== (i == 3)) begin
                bad++;
                $display("FAIL full_drain%0d fire=%b done=%b want 0/%b",
                         i, fire, done, (i == 3));
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (fire !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL full_extra%0d fire=%b busy=%b want 0/0",
                         i, fire, busy);
            end
        end
    endtask

    task automatic test_gap();
        s_valid = 1'b1;
        s_data = 8'h01;
        s_last = 1'b0;
        step();
        s_valid = 1'b0;
        step();
        total++;
        if (fire !== 1'b1 || out_a !== 8'h01) begin
            bad++;
            $display("FAIL gap_fire0 fire=%b out_a=%h want 1/01", fire, out_a);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                s_valid = 1'b1;
                s_data = 8'h02;
                s_last = 1'b1;
            end
            step();
            total++;
            if (fire !== 1'b0 || busy !== 1'b1 || out_a !== 8'h01) begin
                bad++;
                $display("FAIL gap_bubble%0d fire=%b busy=%b out_a=%h want 0/1/01",
                         i, fire, busy, out_a);
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        step();
        total++;
        if (fire !== 1'b1 || out_a !== 8'h02) begin
            bad++;
            $display("FAIL gap_fire1 fire=%b out_a=%h want 1/02", fire, out_a);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (fire !== 1'b0 || done !== (i == 3)) begin
                bad++;
                $display("FAIL gap_drain%0d fire=%b done=%b want 0/%b",
                         i, fire, done, (i == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_data = 8'hA0 + 8'(k);
            s_last = (k == 3);
            step();
            if (k > 0) begin
                total++;
                if (fire !== 1'b1 || out_a !== (8'hA0 + 8'(k - 1))) begin
                    bad++;
                    $display("FAIL b2b_fire%0d fire=%b out_a=%h want 1/%h",
                             k - 1, fire, out_a, 8'hA0 + 8'(k - 1));
                end
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        step();
        total++;
        if (fire !== 1'b1 || out_a !== 8'hA3) begin
            bad++;
            $display("FAIL b2b_fire3 fire=%b out_a=%h want 1/a3", fire, out_a);
        end
        s_valid = 1'b1;
        s_data = 8'hB0;
        s_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            s_valid = 1'b0;
            total++;
            if (fire !== 1'b0 || done !== (i == 3)) begin
                bad++;
                $display("FAIL b2b_drain%0d fire=%b done=%b want 0/%b",
                         i, fire, done, (i == 3));
            end
        end
        step();
        total++;
        if (fire !== 1'b1 || out_a !== 8'hB0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_next fire=%b out_a=%h done=%b want 1/b0/0",
                     fire, out_a, done);
        end
        s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (done !== (i == 3)) begin
                bad++;
                $display("FAIL b2b_done%0d done=%b want %b", i, done, (i == 3));
            end
        end
    endtask

`ifdef PE_FEED_CNT_EN
    task automatic test_fire_cnt();
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_data = 8'h50 + 8'(k);
            s_last = (k == 4);
            step();
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (fire_cnt !== 16'd5 || done !== (i == 3)) begin
                bad++;
                $display("FAIL cnt_drain%0d fire_cnt=%0d done=%b want 5/%b",
                         i, fire_cnt, done, (i == 3));
            end
        end
        s_valid = 1'b1;
        s_data = 8'h60;
        s_last = 1'b1;
        step();
        s_valid = 1'b0;
        s_last = 1'b0;
        step();
        total++;
        if (fire_cnt !== 16'd0 || fire !== 1'b1) begin
            bad++;
            $display("FAIL cnt_clear fire_cnt=%0d fire=%b want 0/1", fire_cnt, fire);
        end
        step();
        total++;
        if (fire_cnt !== 16'd1) begin
            bad++;
            $display("FAIL cnt_next fire_cnt=%0d want 1", fire_cnt);
        end
        for (int i = 0; i < 4; i++) step();
    endtask
`endif

    task automatic test_reset_mid();
        s_valid = 1'b1;
        s_data = 8'hC0;
        s_last = 1'b1;
        step();
        s_data = 8'hC1;
        s_last = 1'b0;
        step();
        s_data = 8'hC2;
        s_last = 1'b1;
        step();
        s_valid = 1'b0;
        s_last = 1'b0;
        total++;
        if (busy !== 1'b1 || fire !== 1'b0) begin
            bad++;
            $display("FAIL mid_drain busy=%b fire=%b want 1/0", busy, fire);
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if (fire !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
            out_a !== 8'h00 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset fire=%b done=%b busy=%b out_a=%h rdy=%b want 0/0/0/00/1",
                     fire, done, busy, out_a, s_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (fire !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_after%0d fire=%b done=%b busy=%b want 0/0/0",
                         i, fire, done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_hold();
        test_gap();
        test_back_to_back();
`ifdef PE_FEED_CNT_EN
        test_fire_cnt();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
